fft_frame_arbiter: RTL and testbench
====================================

Name: fft_frame_arbiter

Overview:
- Shares one fft_core between N_REQ streaming requesters.
- Grants whole frames of FRAME_LEN samples: frame-atomic, round-robin by default. Records the owner of each granted frame in a tag FIFO.
- Routes each fft_core output frame back to the requester that supplied the matching input frame.
- Sits between the sample sources and fft_core; all links use the valid/ready handshake.

Parameters:
- DATA_WIDTH, 50, packed complex sample width (upper half real, lower half imaginary; passed through untouched).
- N_REQ, 2, number of requesters (2..8).
- FRAME_LEN, 8, samples per FFT frame (power of two, >= 2).
- TAG_DEPTH, 4, maximum frames in flight inside fft_core (power of two).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_signal_i  in  N_REQ*DATA_WIDTH  requester samples; requester k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_valid_i  in  N_REQ  per-requester sample valid.
- req_ready_o  out  N_REQ  per-requester sample ready.
- core_signal_o  out  DATA_WIDTH  sample to fft_core signal_i.
- core_valid_o  out  1  to fft_core valid_i.
- core_ready_i  in  1  from fft_core ready_o.
- core_signal_i  in  DATA_WIDTH  fft_core result (signal_o).
- core_valid_i  in  1  fft_core valid_o.
- core_ready_o  out  1  to fft_core ready_i.
- res_signal_o  out  DATA_WIDTH  result sample, broadcast to all requesters.
- res_valid_o  out  N_REQ  per-requester result valid.
- res_ready_i  in  N_REQ  per-requester result ready.
- grant_o  out  $clog2(N_REQ) (min 1)  current or last owner of the input path.
- busy_o  out  1  high in STREAM or while the tag FIFO is non-empty.

Behaviour:
- Reset:
  - state=IDLE; in_cnt=0; out_cnt=0; tag FIFO empty.
  - last_grant=N_REQ-1, so requester 0 wins first.
  - All ready/valid outputs 0; grant_o=0; busy_o=0; core_signal_o=0.
- A reset asserted mid-frame abandons the partial frame and flushes all tags. No recovery is attempted; fft_core is reset in parallel.
- IDLE:
  - Arbitrates when any req_valid_i bit is set and the tag FIFO is not full.
  - Round-robin search starts at last_grant+1, wrapping modulo N_REQ.
  - Winner is registered into grant; next state STREAM. Arbitration costs 1 cycle; no sample moves in IDLE.
  - With the tag FIFO full, the block stays in IDLE and all req_ready_o are 0.
- STREAM:
  - Combinational pass-through from requester grant: core_signal_o = its slice, core_valid_o = req_valid_i[grant], req_ready_o[grant] = core_ready_i.
  - All other req_ready_o bits are 0.
  - A beat is valid&&ready. in_cnt increments per beat. A valid gap does not release the grant.
  - On the beat with in_cnt==FRAME_LEN-1: push grant into the tag FIFO, in_cnt<=0, last_grant<=grant, next state IDLE.
- Output routing:
  - With the tag FIFO non-empty, head tag h gives res_valid_o[h] = core_valid_i and core_ready_o = res_ready_i[h]. All other res_valid_o bits are 0.
  - res_signal_o = core_signal_i.
  - With the tag FIFO empty, core_ready_o=0 and res_valid_o=0. An unexpected core output stalls rather than being misrouted.
  - out_cnt counts output beats. On the beat with out_cnt==FRAME_LEN-1: pop, out_cnt<=0.
- Push and pop in the same cycle: both take effect and the occupancy is unchanged.
- A push when full cannot occur, because arbitration is gated by full.
- grant_o holds its value through IDLE.

Optional Feature:
- FFT_ARB_FIXED_PRIO_EN defined: arbitration in IDLE is fixed priority. The lowest-index valid requester always wins and last_grant is ignored.
- Undefined: round-robin as above.
- Ports and all other behaviour are identical in both builds.

Test Plan:
- Reset, then requester 0 alone sends 8 samples (values 1..8) with core_ready_i=1 -> IDLE cycle, then 8 consecutive core beats; tag FIFO holds 1 entry with value 0; busy_o=1.
- Both requesters continuously valid -> frames granted in the order 0,1,0,1. Every frame is 8 contiguous beats from a single requester, with a 1-cycle gap between frames. With FFT_ARB_FIXED_PRIO_EN -> all frames go to requester 0.
- Requester 1 deasserts valid for 3 cycles mid-frame after beat 4 -> grant stays 1, in_cnt holds at 4, and the frame completes with 8 beats; requester 0 gets no ready during the frame.
- Model fft_core returning two 8-beat frames tagged 1 then 0 -> res_valid_o=2'b10 for beats 1-8, then 2'b01. Drop res_ready_i[1] for 2 cycles -> core_ready_o=0 for those cycles.
- Keep core_valid_i=0 until 4 frames are accepted -> tag FIFO full and req_ready_o=0 in IDLE. Release one output frame -> arbitration resumes the cycle after the pop.
- Assert rst_i after beat 3 of a frame -> next cycle state IDLE, in_cnt=0, FIFO empty, all valid/ready outputs 0. Next grant goes to requester 0.

Source files
------------

// File: rtl/fft_frame_arbiter.sv
// Frame-atomic arbiter sharing one fft_core among N_REQ requesters; a tag FIFO routes
// each result frame back to its source. Define FFT_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module fft_frame_arbiter #(
  parameter  int DATA_WIDTH = 50,
  parameter  int N_REQ      = 2,
  parameter  int FRAME_LEN  = 8,
  parameter  int TAG_DEPTH  = 4,
  localparam int GRANT_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_signal_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]       core_signal_o,
  output logic                        core_valid_o,
  input  logic                        core_ready_i,
  input  logic [DATA_WIDTH-1:0]       core_signal_i,
  input  logic                        core_valid_i,
  output logic                        core_ready_o,
  output logic [DATA_WIDTH-1:0]       res_signal_o,
  output logic [N_REQ-1:0]            res_valid_o,
  input  logic [N_REQ-1:0]            res_ready_i,
  output logic [GRANT_W-1:0]          grant_o,
  output logic                        busy_o
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_next;
  logic [GRANT_W-1:0] grant, last_grant, arb_base, winner, cand, head;
  logic [CNT_W-1:0]   in_cnt, out_cnt;
  logic [GRANT_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     tag_count;
  logic               tag_empty, tag_full, arb_go;
  logic               in_beat, in_last, out_beat, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fixed priority is round-robin searched from a constant base, so index 0 is always tried first.
`ifdef FFT_ARB_FIXED_PRIO_EN
  assign arb_base = GRANT_W'(N_REQ - 1);
`else
  assign arb_base = last_grant;
`endif

  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = GRANT_W'((int'(arb_base) + i) % N_REQ);
      if (req_valid_i[cand]) winner = cand;
    end
  end

  assign tag_empty = (tag_count == '0);
  assign tag_full  = (tag_count == (PTR_W+1)'(TAG_DEPTH));
  assign arb_go    = (state == IDLE) && (|req_valid_i) && !tag_full;
  assign head      = tag_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_go) state_next = STREAM;
      STREAM:  if (in_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = '0;
    core_valid_o  = 1'b0;
    core_signal_o = '0;
    if (state == STREAM) begin
      core_signal_o      = req_signal_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      core_valid_o       = req_valid_i[grant];
      req_ready_o[grant] = core_ready_i;
    end
  end

  assign in_beat = core_valid_o && core_ready_i;
  assign in_last = in_beat && (in_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant      <= '0;
      last_grant <= GRANT_W'(N_REQ - 1);
      in_cnt     <= '0;
    end else begin
      if (arb_go) grant <= winner;
      if (in_beat) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      if (in_last) last_grant <= grant;
    end
  end

  // An empty tag FIFO leaves core_ready_o low, so stray core output stalls instead of misrouting.
  always_comb begin
    res_valid_o  = '0;
    core_ready_o = 1'b0;
    if (!tag_empty) begin
      res_valid_o[head] = core_valid_i;
      core_ready_o      = res_ready_i[head];
    end
  end

  assign res_signal_o = core_signal_i;
  assign out_beat     = core_valid_i && core_ready_o;
  assign pop          = out_beat && (out_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (in_last) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
      out_cnt   <= '0;
    end else begin
      if (in_last) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (out_beat) out_cnt <= pop ? '0 : out_cnt + 1'b1;
      if (in_last && !pop)      tag_count <= tag_count + 1'b1;
      else if (pop && !in_last) tag_count <= tag_count - 1'b1;
    end
  end

  assign grant_o = grant;
  assign busy_o  = (state == STREAM) || !tag_empty;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: scoreboards for the core input path and the result path,
// immediate assertions at every comparison point.
module tb_fft_frame_arbiter;

  localparam int DW = 50;
  localparam int NR = 2;
  localparam int FL = 8;
  localparam int TD = 4;

  typedef struct packed {
    logic [0:0]    dest;
    logic [DW-1:0] data;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] req_signal;
  logic [NR-1:0]    req_valid, req_ready;
  logic [DW-1:0]    core_signal_out, core_signal_in, res_signal;
  logic             core_valid_out, core_ready_in, core_valid_in, core_ready_out;
  logic [NR-1:0]    res_valid, res_ready;
  logic [0:0]       grant;
  logic             busy;

  int            compared = 0;
  int            mismatched = 0;
  int            quota [NR];
  int            snt [NR];
  int            nxt [NR];
  logic [NR-1:0] gap;
  logic          rst_req, core_rdy_req;
  logic [NR-1:0] rdy_req;
  logic [DW-1:0] core_q [$];
  res_t          res_q [$];
  int            owners [TD];

  fft_frame_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_signal_i(req_signal), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .core_signal_o(core_signal_out), .core_valid_o(core_valid_out), .core_ready_i(core_ready_in),
    .core_signal_i(core_signal_in), .core_valid_i(core_valid_in), .core_ready_o(core_ready_out),
    .res_signal_o(res_signal), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sampleValue(input int k, input int n);
    return DW'(k * 256 + n + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectFrame(input int owner);
    for (int i = 0; i < FL; i++) core_q.push_back(sampleValue(owner, nxt[owner] + i));
    nxt[owner] += FL;
  endtask

  task automatic sendResult(input int dest, input int base);
    res_t r;
    for (int i = 0; i < FL; i++) begin
      r.dest = 1'(dest);
      r.data = DW'(base + i);
      res_q.push_back(r);
    end
  endtask

  // One cycle: drive at the falling edge, then sample and score before the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    rst           = rst_req;
    res_ready     = rdy_req;
    core_ready_in = core_rdy_req;
    for (int k = 0; k < NR; k++) begin
      req_valid[k]            = (quota[k] > 0) && !gap[k];
      req_signal[k*DW +: DW]  = sampleValue(k, snt[k]);
    end
    core_valid_in  = (res_q.size() > 0);
    core_signal_in = (res_q.size() > 0) ? res_q[0].data : '0;
    #1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        quota[k]--;
        snt[k]++;
      end
    end
    if (core_valid_out && core_ready_in) begin
      if (core_q.size() == 0) checkOutput("core_unexpected", 64'(core_valid_out), 64'(0));
      else checkOutput("core_data", 64'(core_signal_out), 64'(core_q.pop_front()));
    end
    if (core_valid_in) begin
      checkOutput("res_valid", 64'(res_valid), 64'(NR'(1) << res_q[0].dest));
      checkOutput("res_data", 64'(res_signal), 64'(res_q[0].data));
      checkOutput("res_core_ready", 64'(core_ready_out), 64'(res_ready[res_q[0].dest]));
      if (core_ready_out) void'(res_q.pop_front());
    end
  endtask

  task automatic resetDut();
    rst_req = 1'b1;
    gap = '0;
    rdy_req = '1;
    core_rdy_req = 1'b1;
    core_q.delete();
    res_q.delete();
    for (int k = 0; k < NR; k++) begin
      quota[k] = 0;
      snt[k] = 0;
      nxt[k] = 0;
    end
    applyStimulus();
    applyStimulus();
    rst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_signal = '0;
    req_valid = '0;
    core_ready_in = 1'b0;
    core_signal_in = '0;
    core_valid_in = 1'b0;
    res_ready = '0;
`ifdef FFT_ARB_FIXED_PRIO_EN
    owners = '{0, 0, 0, 0};
`else
    owners = '{0, 1, 0, 1};
`endif

    $display("[TB] reset state");
    resetDut();
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_core_valid", 64'(core_valid_out), 64'(0));
    checkOutput("rst_core_ready", 64'(core_ready_out), 64'(0));
    checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rst_grant", 64'(grant), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_core_signal", 64'(core_signal_out), 64'(0));

    $display("[TB] single requester frame");
    quota[0] = FL;
    expectFrame(0);
    applyStimulus();
    checkOutput("t1_idle_ready", 64'(req_ready), 64'(0));
    checkOutput("t1_idle_valid", 64'(core_valid_out), 64'(0));
    for (int b = 0; b < FL; b++) begin
      applyStimulus();
      checkOutput("t1_valid", 64'(core_valid_out), 64'(1));
      checkOutput("t1_grant", 64'(grant), 64'(0));
    end
    applyStimulus();
    checkOutput("t1_count", 64'(snt[0]), 64'(FL));
    checkOutput("t1_busy", 64'(busy), 64'(1));
    checkOutput("t1_after_valid", 64'(core_valid_out), 64'(0));
    sendResult(0, 'h100);
    for (int b = 0; b < FL; b++) applyStimulus();
    applyStimulus();
    checkOutput("t1_drained_busy", 64'(busy), 64'(0));
    checkOutput("t1_drained_res_valid", 64'(res_valid), 64'(0));

    $display("[TB] contending requesters, then full tag FIFO");
    resetDut();
    quota[0] = 40;
    quota[1] = 24;
    for (int f = 0; f < TD; f++) begin
      expectFrame(owners[f]);
      applyStimulus();
      checkOutput("t2_gap_valid", 64'(core_valid_out), 64'(0));
      checkOutput("t2_gap_ready", 64'(req_ready), 64'(0));
      for (int b = 0; b < FL; b++) begin
        applyStimulus();
        checkOutput("t2_valid", 64'(core_valid_out), 64'(1));
        checkOutput("t2_grant", 64'(grant), 64'(owners[f]));
      end
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("t5_full_ready", 64'(req_ready), 64'(0));
      checkOutput("t5_full_valid", 64'(core_valid_out), 64'(0));
      checkOutput("t5_full_busy", 64'(busy), 64'(1));
    end
    sendResult(owners[0], 'h200);
    for (int b = 0; b < FL; b++) begin
      applyStimulus();
      checkOutput("t5_drain_ready", 64'(req_ready), 64'(0));
    end
    expectFrame(0);
    applyStimulus();
    checkOutput("t5_arb_ready", 64'(req_ready), 64'(0));
    applyStimulus();
    checkOutput("t5_resume_valid", 64'(core_valid_out), 64'(1));
    checkOutput("t5_resume_grant", 64'(grant), 64'(0));

    $display("[TB] valid gap mid-frame");
    resetDut();
    quota[1] = FL;
    expectFrame(1);
    applyStimulus();
    quota[0] = FL;
    for (int b = 0; b < 4; b++) begin
      applyStimulus();
      checkOutput("t3_ready_a", 64'(req_ready), 64'(2'b10));
      checkOutput("t3_grant_a", 64'(grant), 64'(1));
    end
    gap[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("t3_gap_valid", 64'(core_valid_out), 64'(0));
      checkOutput("t3_gap_ready", 64'(req_ready), 64'(2'b10));
      checkOutput("t3_gap_grant", 64'(grant), 64'(1));
    end
    gap[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      applyStimulus();
      checkOutput("t3_ready_b", 64'(req_ready), 64'(2'b10));
      checkOutput("t3_valid_b", 64'(core_valid_out), 64'(1));
    end
    applyStimulus();
    checkOutput("t3_count", 64'(snt[1]), 64'(FL));
    checkOutput("t3_end_valid", 64'(core_valid_out), 64'(0));

    $display("[TB] result routing with backpressure");
    resetDut();
    quota[1] = FL;
    expectFrame(1);
    for (int c = 0; c < FL + 1; c++) applyStimulus();
    quota[0] = FL;
    expectFrame(0);
    for (int c = 0; c < FL + 1; c++) applyStimulus();
    checkOutput("t4_busy", 64'(busy), 64'(1));
    sendResult(1, 'h300);
    sendResult(0, 'h400);
    for (int i = 0; i < 2 * FL + 2; i++) begin
      rdy_req = (i == 3 || i == 4) ? 2'b01 : 2'b11;
      applyStimulus();
      if (i == 3 || i == 4) checkOutput("t4_stall", 64'(core_ready_out), 64'(0));
    end
    rdy_req = 2'b11;
    checkOutput("t4_drained", 64'(res_q.size()), 64'(0));
    applyStimulus();
    checkOutput("t4_idle_busy", 64'(busy), 64'(0));
    checkOutput("t4_idle_res_valid", 64'(res_valid), 64'(0));

    $display("[TB] reset mid-frame");
    resetDut();
    quota[1] = FL;
    expectFrame(1);
    applyStimulus();
    for (int b = 0; b < 3; b++) applyStimulus();
    quota[0] = FL;
    rst_req = 1'b1;
    applyStimulus();
    rst_req = 1'b0;
    core_q.delete();
    applyStimulus();
    checkOutput("t6_core_valid", 64'(core_valid_out), 64'(0));
    checkOutput("t6_req_ready", 64'(req_ready), 64'(0));
    checkOutput("t6_res_valid", 64'(res_valid), 64'(0));
    checkOutput("t6_core_ready", 64'(core_ready_out), 64'(0));
    checkOutput("t6_busy", 64'(busy), 64'(0));
    checkOutput("t6_grant", 64'(grant), 64'(0));
    expectFrame(0);
    applyStimulus();
    checkOutput("t6_next_grant", 64'(grant), 64'(0));
    checkOutput("t6_next_valid", 64'(core_valid_out), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
